// File: rtl/mem_req_packer.sv
// Credit-gated request packer: serialises read/write requests into a
// header beat plus write data beats for the credit buffer write side.
module mem_req_packer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             re_clk,
    input  logic             re_reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [3:0]       req_len,
    input  logic [WIDTH-6:0] req_addr,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    re_credit,
    output logic             re_valid,
    output logic [WIDTH-1:0] data_in,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nx;
    logic             valid_nx;
    logic [WIDTH-1:0] data_nx;
    logic [CW:0]      need;
    logic             accept;
    logic [WIDTH-1:0] header;

    assign header = {req_write, req_len, req_addr};
    assign busy   = (state == DATA);

    // A registered beat not yet seen by the buffer still consumes a credit.
    always_comb begin
        need = (CW+1)'(1) + (CW+1)'(re_valid);
        if (req_write) begin
            need = need + (CW+1)'(req_len) + (CW+1)'(1);
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        valid_nx    = 1'b0;
        data_nx     = data_in;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        accept      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = re_reset_n && ({1'b0, re_credit} >= need);
                accept    = req_valid && req_ready;
                if (accept) begin
                    valid_nx = 1'b1;
                    data_nx  = header;
                    if (req_write) begin
                        state_nx = DATA;
                        cnt_nx   = req_len;
                    end
                end
            end
            DATA: begin
                wdata_ready = re_reset_n;
                if (wdata_valid) begin
                    valid_nx = 1'b1;
                    data_nx  = wdata;
                    if (cnt == 4'd0) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge re_clk or negedge re_reset_n) begin
        if (!re_reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            re_valid <= 1'b0;
            data_in  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            re_valid <= valid_nx;
            data_in  <= data_nx;
        end
    end

endmodule

// File: tb/tb_mem_req_packer.sv
// Randomised and directed bench for mem_req_packer against a
// burst-level reference model.
module tb_mem_req_packer;

    localparam int W  = 32;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [3:0]    req_len = '0;
    logic [W-6:0]  req_addr = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [W-1:0]  wdata = '0;
    logic [CW-1:0] credit = '0;
    logic          re_valid;
    logic [W-1:0]  data_in;
    logic          busy;

    int tests = 0;
    int fails = 0;

    // Model: remaining data beats of the open write burst (0 = idle),
    // plus the expected registered beat.
    int          rem = 0;
    bit          mv = 1'b0;
    logic [W-1:0] md = '0;

    mem_req_packer #(.DEPTH(1024), .WIDTH(W)) dut (
        .re_clk     (clk),
        .re_reset_n (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_len    (req_len),
        .req_addr   (req_addr),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .re_credit  (credit),
        .re_valid   (re_valid),
        .data_in    (data_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int need_of(bit w, logic [3:0] l, bit v);
        return 1 + (w ? int'(l) + 1 : 0) + (v ? 1 : 0);
    endfunction

    function automatic bit model_rr();
        return rst_n && rem == 0 &&
               int'(credit) >= need_of(req_write, req_len, mv);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0;
            mv  = 1'b0;
            md  = '0;
        end else if (rem == 0) begin
            if (req_valid && model_rr()) begin
                mv = 1'b1;
                md = {req_write, req_len, req_addr};
                if (req_write) rem = int'(req_len) + 1;
            end else begin
                mv = 1'b0;
            end
        end else if (wdata_valid) begin
            mv = 1'b1;
            md = wdata;
            rem--;
        end else begin
            mv = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_req_ready", 32'(req_ready), 32'(model_rr()));
        chk("cmp_wdata_ready", 32'(wdata_ready),
            32'(rst_n && rem != 0));
        chk("cmp_busy", 32'(busy), 32'(rem != 0));
        chk("cmp_re_valid", 32'(re_valid), 32'(mv));
        chk("cmp_data_in", data_in, md);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit v, bit w, logic [3:0] l, logic [W-6:0] a);
        req_valid = v;
        req_write = w;
        req_len   = l;
        req_addr  = a;
    endtask

    initial begin
        int beats;
        int gaps;
        bit hs;
        bit pat [6];

        cycle();
        cycle();
        chk("rst_re_valid", 32'(re_valid), 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Single read
        credit = 11'd1024;
        set_req(1'b1, 1'b0, 4'd3, 27'h123);
        #1 chk("rd_ready", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
        chk("rd_valid", 32'(re_valid), 32'd1);
        chk("rd_hdr", data_in, 32'h1800_0123);
        cycle();
        chk("rd_valid_drop", 32'(re_valid), 32'd0);

        // Write len 1, no bubbles
        set_req(1'b1, 1'b1, 4'd1, 27'h40);
        cycle();
        req_valid   = 1'b0;
        wdata_valid = 1'b1;
        wdata       = 32'hAAAA_0001;
        chk("wr_hdr", data_in, 32'h8800_0040);
        chk("wr_busy0", 32'(busy), 32'd1);
        cycle();
        wdata = 32'hAAAA_0002;
        chk("wr_d0", data_in, 32'hAAAA_0001);
        chk("wr_busy1", 32'(busy), 32'd1);
        cycle();
        wdata_valid = 1'b0;
        chk("wr_d1", data_in, 32'hAAAA_0002);
        chk("wr_busy_end", 32'(busy), 32'd0);
        cycle();

        // Credit boundary for a 16-beat write
        credit = 11'd16;
        set_req(1'b1, 1'b1, 4'd15, 27'h200);
        #1 chk("cr16_block", 32'(req_ready), 32'd0);
        credit = 11'd17;
        #1 chk("cr17_accept", 32'(req_ready), 32'd1);
        cycle();
        req_valid   = 1'b0;
        wdata_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom;
            cycle();
        end
        wdata_valid = 1'b0;
        chk("cr_busy_end", 32'(busy), 32'd0);
        set_req(1'b1, 1'b1, 4'd15, 27'h300);
        #1 chk("cr17_inflight", 32'(req_ready), 32'd0);
        credit = 11'd18;
        #1 chk("cr18_inflight", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        credit    = 11'd1024;
        cycle();

        // Write len 2 with three bubbles
        set_req(1'b1, 1'b1, 4'd2, 27'h7);
        cycle();
        req_valid = 1'b0;
        beats = re_valid ? 1 : 0;
        gaps  = 0;
        pat   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            wdata_valid = pat[i];
            wdata       = 32'h5000_0000 + 32'(i);
            cycle();
            if (re_valid) beats++;
            else gaps++;
        end
        chk("bub_beats", 32'(beats), 32'd4);
        chk("bub_gaps", 32'(gaps), 32'd3);
        chk("bub_idle", 32'(busy), 32'd0);
        #1 chk("idle_wdata_ready", 32'(wdata_ready), 32'd0);
        cycle();
        wdata_valid = 1'b0;
        chk("idle_wdata_ignored", 32'(re_valid), 32'd0);
        cycle();

        // Five back-to-back reads
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b0, 4'(i), 27'(i));
            cycle();
            if (re_valid) beats++;
        end
        req_valid = 1'b0;
        chk("b2b_beats", 32'(beats), 32'd5);
        chk("b2b_last_hdr", data_in, 32'h2000_0004);
        cycle();

        // Credit 1: in-flight beat blocks the second read
        credit = 11'd1;
        set_req(1'b1, 1'b0, 4'd0, 27'h9);
        #1 chk("c1_first", 32'(req_ready), 32'd1);
        cycle();
        #1 chk("c1_second", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        credit    = 11'd1024;
        cycle();

        // Reset in the middle of a len-7 write
        set_req(1'b1, 1'b1, 4'd7, 27'h55);
        cycle();
        req_valid   = 1'b0;
        wdata_valid = 1'b1;
        wdata       = 32'd1;
        cycle();
        wdata = 32'd2;
        set_req(1'b1, 1'b0, 4'd0, 27'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_re_valid", 32'(re_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        chk("mr_wdata_ready", 32'(wdata_ready), 32'd0);
        cycle();
        wdata_valid = 1'b0;
        rst_n       = 1'b1;
        set_req(1'b1, 1'b0, 4'd0, 27'h11);
        #1 chk("mr_after_ready", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
        chk("mr_after_hdr", data_in, 32'h0000_0011);
        cycle();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) credit = 11'd1024;
            else credit = 11'($urandom_range(0, 20));
            wdata_valid = ($urandom_range(0, 9) < 7);
            wdata       = $urandom;
            #1 hs = req_valid && req_ready;
            if (hs || !req_valid) begin
                set_req($urandom_range(0, 1) == 1, 1'($urandom),
                        4'($urandom), 27'($urandom));
            end
            cycle();
        end
        req_valid   = 1'b0;
        wdata_valid = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
